// File: rtl/vending_credit_ctrl.sv
// Credit-and-sale controller: conditions coin/button inputs, keeps the 0..MAX_CREDIT
// credit shown on the display, runs sales and unit-by-unit refunds.
module vending_credit_ctrl #(
  parameter int unsigned MAX_CREDIT  = 99,
  parameter int unsigned PRICE_A     = 7,
  parameter int unsigned PRICE_B     = 12,
  parameter int unsigned DISP_CYCLES = 8,
  parameter int unsigned CHANGE_GAP  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_1,
  input  logic       coin_5,
  input  logic       sel_a,
  input  logic       sel_b,
  input  logic       cancel,
  output logic [6:0] value,
  output logic       dispense_a,
  output logic       dispense_b,
  output logic       change_pulse,
  output logic       coin_reject,
  output logic       short_funds,
  output logic       busy
);

  localparam int unsigned CRED_W  = 7;
  localparam int unsigned SUM_W   = 8;
  localparam int unsigned N_IN    = 5;
  localparam int unsigned CNT_MAX = (DISP_CYCLES > CHANGE_GAP) ? DISP_CYCLES : CHANGE_GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DISPENSE = 2'd1;
  localparam logic [1:0] ST_CHANGE   = 2'd2;

  logic [N_IN-1:0] raw;
  logic [N_IN-1:0] sync1;
  logic [N_IN-1:0] sync2;
  logic [N_IN-1:0] prev;
  logic [N_IN-1:0] ev;

  logic coin_1_ev;
  logic coin_5_ev;
  logic sel_a_ev;
  logic sel_b_ev;
  logic cancel_ev;
  logic coin_any;

  logic [SUM_W-1:0] coin_inc;
  logic [SUM_W-1:0] coin_sum;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CRED_W-1:0] credit_nxt;
  logic              disp_a_nxt;
  logic              disp_b_nxt;
  logic              chg_nxt;
  logic              rej_nxt;
  logic              short_nxt;

  assign raw = {cancel, sel_b, sel_a, coin_5, coin_1};

  // Two-flop synchronizer plus registered rising-edge detect; one event per held level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      ev    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prev  <= sync2;
      ev    <= sync2 & ~prev;
    end
  end

  assign coin_1_ev = ev[0];
  assign coin_5_ev = ev[1];
  assign sel_a_ev  = ev[2];
  assign sel_b_ev  = ev[3];
  assign cancel_ev = ev[4];
  assign coin_any  = coin_1_ev | coin_5_ev;

  assign coin_inc = (coin_1_ev ? SUM_W'(1) : SUM_W'(0)) + (coin_5_ev ? SUM_W'(5) : SUM_W'(0));
  assign coin_sum = SUM_W'(value) + coin_inc;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      value        <= '0;
      dispense_a   <= 1'b0;
      dispense_b   <= 1'b0;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      short_funds  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      value        <= credit_nxt;
      dispense_a   <= disp_a_nxt;
      dispense_b   <= disp_b_nxt;
      change_pulse <= chg_nxt;
      coin_reject  <= rej_nxt;
      short_funds  <= short_nxt;
      busy         <= (state_nxt != ST_IDLE);
    end
  end

  // Next state, credit and strobes
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    credit_nxt = value;
    disp_a_nxt = dispense_a;
    disp_b_nxt = dispense_b;
    chg_nxt    = 1'b0;
    rej_nxt    = 1'b0;
    short_nxt  = 1'b0;

    case (state)
      ST_IDLE: begin
        disp_a_nxt = 1'b0;
        disp_b_nxt = 1'b0;
        if (cancel_ev) begin
          if (value != '0) begin
            state_nxt = ST_CHANGE;
            cnt_nxt   = CNT_W'(CHANGE_GAP - 1);
          end
        end else if (sel_a_ev) begin
          if (value >= CRED_W'(PRICE_A)) begin
            credit_nxt = value - CRED_W'(PRICE_A);
            state_nxt  = ST_DISPENSE;
            cnt_nxt    = CNT_W'(DISP_CYCLES - 1);
            disp_a_nxt = 1'b1;
          end else begin
            short_nxt = 1'b1;
          end
        end else if (sel_b_ev) begin
          if (value >= CRED_W'(PRICE_B)) begin
            credit_nxt = value - CRED_W'(PRICE_B);
            state_nxt  = ST_DISPENSE;
            cnt_nxt    = CNT_W'(DISP_CYCLES - 1);
            disp_b_nxt = 1'b1;
          end else begin
            short_nxt = 1'b1;
          end
        end

        // Coins only count while the machine stays idle this cycle
        if (coin_any) begin
          if (state_nxt != ST_IDLE) begin
            rej_nxt = 1'b1;
          end else if (coin_sum <= SUM_W'(MAX_CREDIT)) begin
            credit_nxt = coin_sum[CRED_W-1:0];
          end else begin
            rej_nxt = 1'b1;
          end
        end
      end

      ST_DISPENSE: begin
        rej_nxt = coin_any;
        if (cnt == '0) begin
          state_nxt  = ST_IDLE;
          disp_a_nxt = 1'b0;
          disp_b_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      ST_CHANGE: begin
        rej_nxt    = coin_any;
        disp_a_nxt = 1'b0;
        disp_b_nxt = 1'b0;
        if (cnt == '0) begin
          chg_nxt    = 1'b1;
          credit_nxt = value - CRED_W'(1);
          cnt_nxt    = CNT_W'(CHANGE_GAP - 1);
          if (value == CRED_W'(1)) begin
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      default: begin
        state_nxt  = ST_IDLE;
        disp_a_nxt = 1'b0;
        disp_b_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_vending_credit_ctrl.sv
// Directed self-checking bench for vending_credit_ctrl.
module tb_vending_credit_ctrl;

  localparam logic [4:0] B_C1  = 5'b00001;
  localparam logic [4:0] B_C5  = 5'b00010;
  localparam logic [4:0] B_SA  = 5'b00100;
  localparam logic [4:0] B_SB  = 5'b01000;
  localparam logic [4:0] B_CAN = 5'b10000;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn;
  logic [6:0] value;
  logic       dispense_a;
  logic       dispense_b;
  logic       change_pulse;
  logic       coin_reject;
  logic       short_funds;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic clr;
  int cnt_disp_a, cnt_disp_b, cnt_change, cnt_reject, cnt_short, cnt_busy, cnt_multi;

  always #5 clk = ~clk;

  vending_credit_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .coin_1       (btn[0]),
    .coin_5       (btn[1]),
    .sel_a        (btn[2]),
    .sel_b        (btn[3]),
    .cancel       (btn[4]),
    .value        (value),
    .dispense_a   (dispense_a),
    .dispense_b   (dispense_b),
    .change_pulse (change_pulse),
    .coin_reject  (coin_reject),
    .short_funds  (short_funds),
    .busy         (busy)
  );

  // Cycle counters for strobes, sampled on the falling edge
  always @(negedge clk) begin
    if (clr) begin
      cnt_disp_a = 0; cnt_disp_b = 0; cnt_change = 0; cnt_reject = 0;
      cnt_short  = 0; cnt_busy   = 0; cnt_multi  = 0;
    end else begin
      cnt_disp_a += int'(dispense_a);
      cnt_disp_b += int'(dispense_b);
      cnt_change += int'(change_pulse);
      cnt_reject += int'(coin_reject);
      cnt_short  += int'(short_funds);
      cnt_busy   += int'(busy);
      if (int'(dispense_a) + int'(dispense_b) + int'(change_pulse) > 1) cnt_multi += 1;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] m);
    btn = m;
    tick(); tick();
    btn = '0;
    repeat (4) tick();
  endtask

  task automatic clear_counts();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic do_reset();
    btn = '0;
    #2 rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    btn = '0;
    clr = 1'b1;
    repeat (2) tick();
    check("rst_value", int'(value), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_strobes", int'({dispense_a, dispense_b, change_pulse, coin_reject, short_funds}), 0);
    clr = 1'b0;
    rst = 1'b1;

    // First coin latency: rise before edge 0, credited at edge 3
    btn = B_C5;
    tick(); tick(); tick();
    check("lat_edge2", int'(value), 0);
    tick();
    check("lat_edge3", int'(value), 5);
    btn = '0;
    repeat (4) tick();
    check("lat_no_reject", cnt_reject, 0);

    // Sale of item B
    do_reset();
    press(B_C5); press(B_C5); press(B_C1); press(B_C1);
    check("b_credit", int'(value), 12);
    clear_counts();
    press(B_SB);
    repeat (10) tick();
    check("b_disp_cycles", cnt_disp_b, 8);
    check("b_busy_cycles", cnt_busy, 8);
    check("b_no_disp_a", cnt_disp_a, 0);
    check("b_value", int'(value), 0);
    check("b_idle", int'(busy), 0);

    // Short funds then sale of item A
    do_reset();
    press(B_C5); press(B_C1);
    clear_counts();
    press(B_SA);
    check("a_short_pulse", cnt_short, 1);
    check("a_short_value", int'(value), 6);
    check("a_short_nodisp", cnt_disp_a, 0);
    press(B_C1);
    check("a_credit7", int'(value), 7);
    clear_counts();
    press(B_SA);
    repeat (10) tick();
    check("a_disp_cycles", cnt_disp_a, 8);
    check("a_value", int'(value), 0);

    // Credit ceiling
    do_reset();
    for (int i = 0; i < 19; i++) press(B_C5);
    press(B_C1); press(B_C1);
    check("cap_97", int'(value), 97);
    clear_counts();
    press(B_C5);
    check("cap_c5_reject", cnt_reject, 1);
    check("cap_c5_value", int'(value), 97);
    clear_counts();
    press(B_C1 | B_C5);
    check("cap_pair_reject", cnt_reject, 1);
    check("cap_pair_value", int'(value), 97);
    press(B_C1); press(B_C1);
    check("cap_99", int'(value), 99);
    check("cap_99_noreject", cnt_reject, 1);
    press(B_C1);
    check("cap_over_reject", cnt_reject, 2);
    check("cap_over_value", int'(value), 99);

    // Refund of 3 units with a coin arriving mid-refund
    do_reset();
    press(B_C1); press(B_C1); press(B_C1);
    clear_counts();
    btn = B_CAN;
    tick(); tick();
    btn = '0;
    tick(); tick();
    check("ref_entry_busy", int'(busy), 1);
    check("ref_entry_value", int'(value), 3);
    repeat (3) tick();
    check("ref_gap_nopulse", int'(change_pulse), 0);
    tick();
    check("ref_p1", int'(change_pulse), 1);
    check("ref_p1_value", int'(value), 2);
    tick();
    check("ref_p1_single", int'(change_pulse), 0);
    btn = B_C1;
    tick(); tick();
    btn = '0;
    tick();
    check("ref_p2", int'(change_pulse), 1);
    check("ref_p2_value", int'(value), 1);
    tick();
    check("ref_coin_reject", int'(coin_reject), 1);
    check("ref_coin_value", int'(value), 1);
    repeat (3) tick();
    check("ref_p3", int'(change_pulse), 1);
    check("ref_p3_value", int'(value), 0);
    check("ref_done_busy", int'(busy), 0);
    repeat (6) tick();
    check("ref_total_pulses", cnt_change, 3);

    // Asynchronous reset during a sale
    do_reset();
    press(B_C5); press(B_C1); press(B_C1);
    btn = B_SA;
    tick(); tick();
    btn = '0;
    tick(); tick();
    check("abort_disp_started", int'(dispense_a), 1);
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    check("abort_disp_low", int'(dispense_a), 0);
    check("abort_value", int'(value), 0);
    check("abort_busy", int'(busy), 0);
    tick();
    rst = 1'b1;

    // Cancel beats a simultaneous select
    press(B_C5); press(B_C5);
    check("prio_credit", int'(value), 10);
    clear_counts();
    press(B_CAN | B_SA);
    repeat (45) tick();
    check("prio_pulses", cnt_change, 10);
    check("prio_no_disp", cnt_disp_a, 0);
    check("prio_no_short", cnt_short, 0);
    check("prio_value", int'(value), 0);
    check("prio_busy", int'(busy), 0);
    check("prio_exclusive", cnt_multi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
